mux_tree_cfgchain: RTL and testbench
====================================

Name: mux_tree_cfgchain

Overview:
- Parametrised successor to the fixed 16-input routing mux.
- N-input binary-encoded mux with a const1 pad leaf, plus integrated configuration-chain storage: serial shift shadow register, commit to active register, shift-count qualification, error flag.
- Instantiated in switch/connection blocks; chains daisy-chain via ccff_head/ccff_tail.

Parameters:
- NUM_IN, 16, number of data inputs (>=2).
- SEL_W, $clog2(NUM_IN+1), select code width (derived; do not override).
- CHAIN_LEN, SEL_W (+1 when parity feature compiled in), shadow chain length in bits.

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge.
- pReset  input  1  synchronous, active-high reset.
- cfg_shift_en  input  1  shift ccff_head into the shadow register this cycle.
- ccff_head  input  1  serial config data in.
- ccff_tail  output  1  serial config data out (shadow MSB).
- cfg_commit  input  1  single-cycle strobe: copy shadow to active.
- in  input  NUM_IN  data inputs, index 0..NUM_IN-1.
- out  output  1  selected data (combinational from the active register and in).
- cfg_valid  output  1  high once any commit has succeeded since reset.
- cfg_err  output  1  sticky configuration error.

Behaviour:
- Shadow register: CHAIN_LEN bits.
  - When cfg_shift_en=1: shadow <= {shadow[CHAIN_LEN-2:0], ccff_head}.
  - Load MSB first. ccff_tail = shadow[CHAIN_LEN-1].
- Shift counter: counts shifts since reset or last commit attempt. Saturates at CHAIN_LEN and never wraps.
- Commit (cfg_commit=1):
  - If count==CHAIN_LEN (and parity passes, when compiled in): active <= shadow[SEL_W-1:0] and cfg_valid <= 1.
  - Otherwise: active is unchanged and cfg_err <= 1.
  - Either way count <= 0.
- Select decode: out = in[active] when active < NUM_IN; out = 1 (const1) when active >= NUM_IN.
- Latency: a new code drives out combinationally in the cycle after the commit edge. No clocked path from in to out.
- Simultaneous shift and commit:
  - Commit uses the pre-shift shadow and pre-shift count.
  - The shift still occurs.
  - count <= 1, because the shift is counted after the clear.
- Shift while count is saturated: the shadow keeps shifting, and the last CHAIN_LEN bits win.
- Reset values (pReset=1 at an edge): shadow=0, count=0, active=NUM_IN (so out=1), cfg_valid=0, cfg_err=0. Hence ccff_tail=0.
- Reset overrides a shift or commit in the same cycle. Reset mid-shift discards the partial shadow.
- cfg_err is cleared only by pReset.

Optional Feature:
- Macro: MUX_CFG_PARITY_EN.
- Compiled in:
  - CHAIN_LEN = SEL_W+1, and shadow[SEL_W] is an even-parity bit over the whole shadow.
  - A commit with odd overall parity is rejected: active is held and cfg_err=1.
- Compiled out:
  - CHAIN_LEN = SEL_W, and there is no parity check.
  - Commit is qualified only by the shift count.

Decomposition:
- Shared package mux_tree_pkg holds:
  - a sel_width(n) constant function returning clog2(n+1);
  - the CONST1 pad value;
  - the even-parity helper function.
- One sub-module is natural: mux_tree_cfgchain_sreg (shadow register, shift counter, ccff_tail), reusable by wider mux generators.
- Decode and active register stay in the top.

Test Plan (NUM_IN=16, SEL_W=5, parity off unless stated):
- Reset, then hold in=16'hFFFF, then in=0 → out=1 throughout, cfg_valid=0, ccff_tail=0.
- Shift 0,0,0,1,1 (code 3), commit; drive in[3]=1 with all others 0 → out=1; toggle in[3] → out follows; cfg_valid=1, cfg_err=0.
- Shift only 3 bits, then commit → active keeps its previous code, cfg_err=1. A later valid 5-bit shift plus commit succeeds, and cfg_err stays 1.
- Shift code 10000 (16) then commit → out=1 regardless of in; shift 11111 (31) then commit → out=1.
- In a single cycle, assert the commit together with the 6th shift (count=5) → commit uses the first 5 bits; next cycle count=1. ccff_tail after 5 more shifts reproduces the fed bits delayed by 5 cycles.
- MUX_CFG_PARITY_EN defined: 6-bit stream with correct parity for code 7 → out=in[7]. Flip the parity bit → commit rejected, cfg_err=1, out unchanged.

Source files
------------

// File: rtl/mux_tree_pkg.sv
// ----------------------------------------------------------------------------
// mux_tree_pkg
// Shared definitions for the configurable mux-tree family.
//   sel_width(n)  : select code width able to encode n data legs plus one pad
//   CONST1        : value driven by the pad leaf (codes >= NUM_IN)
//   parity_even() : even-parity test used to qualify a configuration word
// ----------------------------------------------------------------------------
package mux_tree_pkg;

    localparam logic CONST1 = 1'b1;

    // Width of the binary select code: codes 0..n-1 pick a data leg, code n
    // (and anything above) picks the constant pad.
    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Returns 1 when the word carries an even number of ones. Callers
    // zero-extend their vector to 32 bits, which does not change parity.
    function automatic logic parity_even(input logic [31:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/mux_tree_cfgchain_sreg.sv
// ----------------------------------------------------------------------------
// mux_tree_cfgchain_sreg
// Serial configuration shadow register with a saturating shift counter.
//   prog_clk      : configuration clock
//   pReset        : synchronous active-high reset
//   cfg_shift_en  : shift ccff_head into the shadow this cycle
//   ccff_head     : serial data in (loaded MSB first)
//   cfg_commit    : commit attempt; restarts the shift count
//   shadow        : parallel view of the shadow register
//   count_full    : CHAIN_LEN shifts seen since reset / last commit attempt
//   ccff_tail     : serial data out (shadow MSB), feeds the next chain link
// ----------------------------------------------------------------------------
module mux_tree_cfgchain_sreg #(
    parameter int CHAIN_LEN = 5
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 cfg_shift_en,
    input  logic                 ccff_head,
    input  logic                 cfg_commit,
    output logic [CHAIN_LEN-1:0] shadow,
    output logic                 count_full,
    output logic                 ccff_tail
);

    localparam int                CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] shadow_r;
    logic [CNT_W-1:0]     count_r;

    // Shadow shift register: new bit enters at the LSB, MSB leaves on ccff_tail.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            shadow_r <= {CHAIN_LEN{1'b0}};
        end else if (cfg_shift_en) begin
            shadow_r <= {shadow_r[CHAIN_LEN-2:0], ccff_head};
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Shift counter: a commit clears it, but a shift in the same cycle is
    // counted after the clear, so shift+commit leaves a count of one.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cfg_commit) begin
            count_r <= cfg_shift_en ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (cfg_shift_en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign shadow     = shadow_r;
    assign count_full = (count_r == CNT_MAX);
    assign ccff_tail  = shadow_r[CHAIN_LEN-1];

endmodule

// File: rtl/mux_tree_cfgchain.sv
// ----------------------------------------------------------------------------
// mux_tree_cfgchain
// NUM_IN-input binary-encoded routing mux with a constant-1 pad leaf and an
// integrated configuration chain (shadow register, commit to active code).
//   prog_clk      : configuration clock, all state on the rising edge
//   pReset        : synchronous active-high reset
//   cfg_shift_en  : shift ccff_head into the shadow register
//   ccff_head     : serial config data in
//   ccff_tail     : serial config data out (shadow MSB)
//   cfg_commit    : single-cycle strobe, copy shadow to the active code
//   in            : data inputs 0..NUM_IN-1
//   out           : selected data, combinational from active code and in
//   cfg_valid     : a commit has succeeded since reset
//   cfg_err       : sticky configuration error (cleared only by pReset)
// Build option MUX_CFG_PARITY_EN: chain grows by one even-parity bit held in
// shadow[SEL_W]; commits with odd overall parity are rejected.
// ----------------------------------------------------------------------------
module mux_tree_cfgchain
    import mux_tree_pkg::*;
#(
    parameter int NUM_IN = 16,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cfg_shift_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    input  logic              cfg_commit,
    input  logic [NUM_IN-1:0] in,
    output logic              out,
    output logic              cfg_valid,
    output logic              cfg_err
);

`ifdef MUX_CFG_PARITY_EN
    localparam int CHAIN_LEN = SEL_W + 1;
`else
    localparam int CHAIN_LEN = SEL_W;
`endif

    // Codes NUM_IN..2**SEL_W-1 all land on constant-1 pad leaves.
    localparam int               PAD_W      = (1 << SEL_W) - NUM_IN;
    localparam logic [SEL_W-1:0] RESET_CODE = SEL_W'(NUM_IN);

    logic [CHAIN_LEN-1:0]      shadow_s;
    logic                      count_full_s;
    logic                      commit_ok_s;
    logic [(1 << SEL_W)-1:0]   leaves_s;
    logic [SEL_W-1:0]          active_r;
    logic                      valid_r;
    logic                      err_r;

    mux_tree_cfgchain_sreg #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_sreg (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .cfg_shift_en (cfg_shift_en),
        .ccff_head    (ccff_head),
        .cfg_commit   (cfg_commit),
        .shadow       (shadow_s),
        .count_full   (count_full_s),
        .ccff_tail    (ccff_tail)
    );

    // Commit qualification: a full chain load, plus even parity when built in.
    always_comb begin
        commit_ok_s = count_full_s;
`ifdef MUX_CFG_PARITY_EN
        commit_ok_s = count_full_s & parity_even(32'(shadow_s));
`endif
    end

    // Active code and status: a rejected commit holds the code and sets the
    // sticky error; only reset clears cfg_err.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            active_r <= RESET_CODE;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else if (cfg_commit && commit_ok_s) begin
            active_r <= shadow_s[SEL_W-1:0];
            valid_r  <= 1'b1;
            err_r    <= err_r;
        end else if (cfg_commit) begin
            active_r <= active_r;
            valid_r  <= valid_r;
            err_r    <= 1'b1;
        end else begin
            active_r <= active_r;
            valid_r  <= valid_r;
            err_r    <= err_r;
        end
    end

    // Leaf vector padded with constant-1 so every code has a defined leaf.
    assign leaves_s  = {{PAD_W{CONST1}}, in};
    assign out       = leaves_s[active_r];
    assign cfg_valid = valid_r;
    assign cfg_err   = err_r;

endmodule

// File: tb/tb_mux_tree_cfgchain.sv
// ----------------------------------------------------------------------------
// tb_mux_tree_cfgchain
// Randomised self-checking bench for mux_tree_cfgchain (NUM_IN=16). A
// behavioural model tracks the shadow word, shift count, active code and
// status flags; expected out is taken straight from the selection rule.
// Honours MUX_CFG_PARITY_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_mux_tree_cfgchain;

    localparam int NUM_IN = 16;
    localparam int SEL_W  = 5;
`ifdef MUX_CFG_PARITY_EN
    localparam int CL = SEL_W + 1;
`else
    localparam int CL = SEL_W;
`endif
    localparam logic [7:0] CL_MASK = 8'((1 << CL) - 1);

    logic              prog_clk = 1'b0;
    logic              pReset = 1'b0;
    logic              cfg_shift_en = 1'b0;
    logic              ccff_head = 1'b0;
    logic              cfg_commit = 1'b0;
    logic [NUM_IN-1:0] in_v = '0;
    logic              ccff_tail;
    logic              out;
    logic              cfg_valid;
    logic              cfg_err;

    int n_total = 0;
    int n_pass  = 0;

    // model state
    logic [7:0] m_shadow;
    int         m_count;
    int         m_code;
    logic       m_valid;
    logic       m_err;

    mux_tree_cfgchain #(.NUM_IN(NUM_IN)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .cfg_shift_en (cfg_shift_en),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .cfg_commit   (cfg_commit),
        .in           (in_v),
        .out          (out),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    function automatic logic exp_out(input int code, input logic [NUM_IN-1:0] v);
        logic [4:0] c;
        c = code[4:0];
        if (code < NUM_IN) return v[c[3:0]];
        return 1'b1;
    endfunction

    function automatic logic exp_tail();
        return m_shadow[CL-1];
    endfunction

    task automatic model_step(input logic sh, input logic hd, input logic cm, input logic rs);
        logic ok;
        if (rs) begin
            m_shadow = 8'd0; m_count = 0; m_code = NUM_IN; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (cm) begin
                ok = (m_count == CL);
`ifdef MUX_CFG_PARITY_EN
                ok = ok && ((^m_shadow) == 1'b0);
`endif
                if (ok) begin
                    m_code  = int'(m_shadow[4:0]);
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_count = 0;
            end
            if (sh) begin
                m_shadow = ((m_shadow << 1) | {7'd0, hd}) & CL_MASK;
                if (m_count < CL) m_count++;
            end
        end
    endtask

    // One clock: drive controls, clock edge, update model, release controls.
    task automatic cyc(input logic sh, input logic hd, input logic cm, input logic rs);
        cfg_shift_en = sh; ccff_head = hd; cfg_commit = cm; pReset = rs;
        @(posedge prog_clk);
        model_step(sh, hd, cm, rs);
        #1;
        cfg_shift_en = 1'b0; cfg_commit = 1'b0; pReset = 1'b0; ccff_head = 1'b0;
    endtask

    // Shift a full code MSB first; with parity, the parity bit goes first.
    task automatic shift_code(input int code);
        logic [7:0] word;
        word = 8'(code) & 8'h1F;
`ifdef MUX_CFG_PARITY_EN
        word[5] = ^word[4:0];
`endif
        for (int i = CL - 1; i >= 0; i--) cyc(1'b1, word[i], 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        in_v = 16'hFFFF; #2;
        n_total++; if (out !== 1'b1) $display("FAIL reset_out_ffff: got %b expected 1", out); else n_pass++;
        in_v = 16'h0000; #2;
        n_total++; if (out !== 1'b1) $display("FAIL reset_out_0000: got %b expected 1", out); else n_pass++;
        n_total++; if (cfg_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cfg_valid); else n_pass++;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", cfg_err); else n_pass++;
        n_total++; if (ccff_tail !== 1'b0) $display("FAIL reset_tail: got %b expected 0", ccff_tail); else n_pass++;
    endtask

    task automatic test_select();
        shift_code(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        in_v = 16'h0008; #2;
        n_total++; if (out !== 1'b1) $display("FAIL sel3_high: got %b expected 1", out); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            in_v = in_v ^ 16'h0008; #2;
            n_total++; if (out !== in_v[3]) $display("FAIL sel3_toggle: got %b expected %b", out, in_v[3]); else n_pass++;
        end
        n_total++; if (cfg_valid !== 1'b1) $display("FAIL sel3_valid: got %b expected 1", cfg_valid); else n_pass++;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL sel3_err: got %b expected 0", cfg_err); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            shift_code(int'($urandom_range(0, 31)));
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) begin
                in_v = 16'($urandom); #2;
                n_total++;
                if (out !== exp_out(m_code, in_v)) $display("FAIL sel_rand code=%0d: got %b expected %b", m_code, out, exp_out(m_code, in_v));
                else n_pass++;
            end
        end
    endtask

    task automatic test_short_shift();
        int held;
        held = m_code;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (cfg_err !== 1'b1) $display("FAIL short_err: got %b expected 1", cfg_err); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            in_v = 16'($urandom); #2;
            n_total++; if (out !== exp_out(held, in_v)) $display("FAIL short_hold: got %b expected %b", out, exp_out(held, in_v)); else n_pass++;
        end
        shift_code(int'($urandom_range(0, 15)));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        in_v = 16'($urandom); #2;
        n_total++; if (out !== exp_out(m_code, in_v)) $display("FAIL short_reload: got %b expected %b", out, exp_out(m_code, in_v)); else n_pass++;
        n_total++; if (cfg_err !== 1'b1) $display("FAIL short_err_sticky: got %b expected 1", cfg_err); else n_pass++;
        n_total++; if (cfg_valid !== 1'b1) $display("FAIL short_valid: got %b expected 1", cfg_valid); else n_pass++;
    endtask

    task automatic test_pad_codes();
        int codes [2] = '{16, 31};
        for (int c = 0; c < 2; c++) begin
            shift_code(codes[c]);
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) begin
                in_v = (j == 0) ? 16'h0000 : 16'($urandom); #2;
                n_total++; if (out !== 1'b1) $display("FAIL pad_code=%0d: got %b expected 1", codes[c], out); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        logic       fed [$];
        bits = 8'($urandom);
        for (int i = CL - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0, 1'b0);
        // commit together with one extra shift: commit sees the first CL bits
        cyc(1'b1, bits[7], 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            in_v = 16'($urandom); #2;
            n_total++; if (out !== exp_out(m_code, in_v)) $display("FAIL overlap_code: got %b expected %b", out, exp_out(m_code, in_v)); else n_pass++;
        end
        n_total++; if (cfg_err !== m_err) $display("FAIL overlap_err: got %b expected %b", cfg_err, m_err); else n_pass++;
        // count restarted at one, so CL-1 more shifts make the next commit legal
        for (int i = 0; i < CL - 1; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        in_v = 16'($urandom); #2;
        n_total++; if (out !== exp_out(m_code, in_v)) $display("FAIL overlap_followup: got %b expected %b", out, exp_out(m_code, in_v)); else n_pass++;
        n_total++; if (cfg_err !== m_err) $display("FAIL overlap_followup_err: got %b expected %b", cfg_err, m_err); else n_pass++;
        // serial pass-through: tail reproduces the stream CL shifts later
        for (int i = 0; i < 20; i++) begin
            bits[0] = 1'($urandom);
            fed.push_back(bits[0]);
            cyc(1'b1, bits[0], 1'b0, 1'b0);
            if (fed.size() >= CL) begin
                n_total++;
                if (ccff_tail !== fed[fed.size() - CL]) $display("FAIL tail_delay i=%0d: got %b expected %b", i, ccff_tail, fed[fed.size() - CL]);
                else n_pass++;
            end
        end
        // saturated count: the last CL bits win
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        n_total++; if (ccff_tail !== exp_tail()) $display("FAIL sat_tail: got %b expected %b", ccff_tail, exp_tail()); else n_pass++;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            in_v = 16'($urandom); #2;
            n_total++; if (out !== exp_out(m_code, in_v)) $display("FAIL sat_commit: got %b expected %b", out, exp_out(m_code, in_v)); else n_pass++;
        end
        n_total++; if (cfg_err !== m_err) $display("FAIL sat_err: got %b expected %b", cfg_err, m_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        in_v = 16'h0000; #2;
        n_total++; if (out !== 1'b1) $display("FAIL rstmid_out: got %b expected 1", out); else n_pass++;
        n_total++; if (cfg_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", cfg_valid); else n_pass++;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", cfg_err); else n_pass++;
        n_total++; if (ccff_tail !== 1'b0) $display("FAIL rstmid_tail: got %b expected 0", ccff_tail); else n_pass++;
        // partial load was discarded: a commit now has a zero count
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (cfg_err !== 1'b1) $display("FAIL rstmid_commit_err: got %b expected 1", cfg_err); else n_pass++;
        n_total++; if (cfg_valid !== 1'b0) $display("FAIL rstmid_commit_valid: got %b expected 0", cfg_valid); else n_pass++;
    endtask

`ifdef MUX_CFG_PARITY_EN
    task automatic test_parity();
        logic [5:0] word;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        word = 6'b1_00111;
        for (int i = 5; i >= 0; i--) cyc(1'b1, word[i], 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            in_v = 16'($urandom); #2;
            n_total++; if (out !== in_v[7]) $display("FAIL par_ok: got %b expected %b", out, in_v[7]); else n_pass++;
        end
        n_total++; if (cfg_err !== 1'b0) $display("FAIL par_ok_err: got %b expected 0", cfg_err); else n_pass++;
        word = 6'b0_00111;
        for (int i = 5; i >= 0; i--) cyc(1'b1, word[i], 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_total++; if (cfg_err !== 1'b1) $display("FAIL par_bad_err: got %b expected 1", cfg_err); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            in_v = 16'($urandom); #2;
            n_total++; if (out !== in_v[7]) $display("FAIL par_bad_hold: got %b expected %b", out, in_v[7]); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_short_shift();
        test_pad_codes();
        test_back_to_back();
        test_reset_mid();
`ifdef MUX_CFG_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
